// File: rtl/port_req_pkg.sv
// ---------------------------------------------------------------------------
// port_req_pkg
// Shared widths and types for the port_requester client initiator.
//   ADDR_W    cluster port address width
//   DATA_W    cluster port data width
//   TAG_W     request tag width
//   NUM_TAGS  number of outstanding requests (2**TAG_W)
//   CNT_W     width of the outstanding-request counter (holds 0..NUM_TAGS)
//   rob_entry_t  one reorder-buffer slot {alloc, done, wen, data}
// ---------------------------------------------------------------------------
package port_req_pkg;

   localparam int ADDR_W   = 12;
   localparam int DATA_W   = 16;
   localparam int TAG_W    = 2;
   localparam int NUM_TAGS = 2 ** TAG_W;
   localparam int CNT_W    = TAG_W + 1;

   typedef struct packed {
      logic              alloc;
      logic              done;
      logic              wen;
      logic [DATA_W-1:0] data;
   } rob_entry_t;

endpackage

// File: rtl/tag_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tag_reorder_buffer
// Tag-indexed reorder buffer. Entries are allocated in issue order by the
// parent, completed in any order by cluster responses, and retired strictly
// in issue order through the head port.
//   clk, reset              clock / async active-high reset
//   alloc_en/tag/wen        allocate slot <tag> for a read or write
//   cmpl_en/tag/data        cluster response for slot <tag>
//   head_valid/data/wen     oldest slot, valid once its response is in
//   head_pop                retire the oldest slot
//   tag_err                 sticky: response for a free or completed slot
// ---------------------------------------------------------------------------
module tag_reorder_buffer
   import port_req_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              alloc_en,
   input  logic [TAG_W-1:0]  alloc_tag,
   input  logic              alloc_wen,
   input  logic              cmpl_en,
   input  logic [TAG_W-1:0]  cmpl_tag,
   input  logic [DATA_W-1:0] cmpl_data,
   output logic              head_valid,
   output logic [DATA_W-1:0] head_data,
   output logic              head_wen,
   input  logic              head_pop,
   output logic              tag_err
);

   rob_entry_t       rob [NUM_TAGS];
   logic [TAG_W-1:0] rptr;
   logic             cmpl_ok;

   // A response is legal only for a slot that is allocated and still waiting.
   // A response colliding with a fresh allocation of the same tag sees the
   // slot as free, so it is flagged and the allocation takes the slot.
   assign cmpl_ok = cmpl_en & rob[cmpl_tag].alloc & ~rob[cmpl_tag].done;

   assign head_valid = rob[rptr].done;
   assign head_data  = rob[rptr].data;
   assign head_wen   = rob[rptr].wen;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_TAGS; i++) begin
            rob[i] <= '0;
         end
         rptr    <= '0;
         tag_err <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_TAGS; i++) begin
            if (alloc_en && alloc_tag == TAG_W'(i)) begin
               rob[i] <= '{alloc: 1'b1, done: 1'b0, wen: alloc_wen, data: '0};
            end else if (head_pop && rptr == TAG_W'(i)) begin
               rob[i].alloc <= 1'b0;
               rob[i].done  <= 1'b0;
            end else if (cmpl_ok && cmpl_tag == TAG_W'(i)) begin
               rob[i].done <= 1'b1;
               // writes carry no read data back to the client
               rob[i].data <= rob[i].wen ? '0 : cmpl_data;
            end
         end
         if (head_pop) begin
            rptr <= rptr + 1'b1;
         end
         if (cmpl_en && !cmpl_ok) begin
            tag_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/port_requester.sv
// ---------------------------------------------------------------------------
// port_requester
// Client-side initiator for one port of the banked memory cluster. Accepts
// client requests over valid/ready, tags them, holds them on the cluster
// port while the cluster freezes its inputs, and returns responses to the
// client in issue order through tag_reorder_buffer.
//   clk, reset                         clock / async active-high reset
//   req_valid/ready/addr/wdata/wen     client request handshake
//   resp_valid/ready/rdata/wen         client response handshake
//   port_req_tag/addr/data/wen/valid   request driven to the cluster
//   freeze_inputs                      cluster is not taking a request
//   port_req_tag_in/data_in/valid_in   response from the cluster
//   tag_err                            sticky illegal-response flag
// ---------------------------------------------------------------------------
module port_requester
   import port_req_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              req_wen,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_wen,
   output logic [TAG_W-1:0]  port_req_tag,
   output logic [ADDR_W-1:0] port_addr,
   output logic [DATA_W-1:0] port_data,
   output logic              port_wen,
   output logic              port_valid,
   input  logic              freeze_inputs,
   input  logic [TAG_W-1:0]  port_req_tag_in,
   input  logic [DATA_W-1:0] port_data_in,
   input  logic              port_valid_in,
   output logic              tag_err
);

   logic [TAG_W-1:0] iptr;
   logic [CNT_W-1:0] count;
   logic             hold_valid;
   logic             take;
   logic             accept;
   logic             retire;

   assign take       = hold_valid & ~freeze_inputs;
   assign port_valid = hold_valid;

   // Ready looks at freeze_inputs directly so a freshly released hold slot
   // can be refilled in the same cycle. The count term uses the registered
   // value, so a retire while full frees a slot only from the next cycle.
   // Ready is also kept low while reset is asserted so every output is 0.
   assign req_ready = ~reset & (count < CNT_W'(NUM_TAGS)) & (~hold_valid | take);
   assign accept    = req_valid & req_ready;
   assign retire    = resp_valid & resp_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_valid   <= 1'b0;
         port_req_tag <= '0;
         port_addr    <= '0;
         port_data    <= '0;
         port_wen     <= 1'b0;
      end else if (accept) begin
         hold_valid   <= 1'b1;
         port_req_tag <= iptr;
         port_addr    <= req_addr;
         port_data    <= req_wdata;
         port_wen     <= req_wen;
      end else if (take) begin
         hold_valid   <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         iptr <= '0;
      end else if (accept) begin
         iptr <= iptr + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else begin
         case ({accept, retire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   tag_reorder_buffer u_rob (
      .clk        (clk),
      .reset      (reset),
      .alloc_en   (accept),
      .alloc_tag  (iptr),
      .alloc_wen  (req_wen),
      .cmpl_en    (port_valid_in),
      .cmpl_tag   (port_req_tag_in),
      .cmpl_data  (port_data_in),
      .head_valid (resp_valid),
      .head_data  (resp_rdata),
      .head_wen   (resp_wen),
      .head_pop   (retire),
      .tag_err    (tag_err)
   );

endmodule

// File: tb/tb_port_requester.sv
// ---------------------------------------------------------------------------
// tb_port_requester
// Self-checking bench for port_requester. A reference model keeps the
// outstanding requests as an issue-ordered queue and the requests already
// taken by the cluster as a pending list; directed scenarios are followed
// by a randomized phase.
// ---------------------------------------------------------------------------
module tb_port_requester;
   import port_req_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              req_wen;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_wen;
   logic [TAG_W-1:0]  port_req_tag;
   logic [ADDR_W-1:0] port_addr;
   logic [DATA_W-1:0] port_data;
   logic              port_wen;
   logic              port_valid;
   logic              freeze_inputs;
   logic [TAG_W-1:0]  port_req_tag_in;
   logic [DATA_W-1:0] port_data_in;
   logic              port_valid_in;
   logic              tag_err;

   always #5 clk = ~clk;

   port_requester dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .req_wen         (req_wen),
      .resp_valid      (resp_valid),
      .resp_ready      (resp_ready),
      .resp_rdata      (resp_rdata),
      .resp_wen        (resp_wen),
      .port_req_tag    (port_req_tag),
      .port_addr       (port_addr),
      .port_data       (port_data),
      .port_wen        (port_wen),
      .port_valid      (port_valid),
      .freeze_inputs   (freeze_inputs),
      .port_req_tag_in (port_req_tag_in),
      .port_data_in    (port_data_in),
      .port_valid_in   (port_valid_in),
      .tag_err         (tag_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [1:0]  tag;
      bit          wen;
      bit          done;
      logic [15:0] data;
   } ent_t;

   ent_t        q[$];      // outstanding requests, oldest first
   logic [1:0]  pend[$];   // tags taken by the cluster, no response yet
   int          m_iptr;
   bit          m_hold;
   logic [1:0]  m_ptag;
   logic [11:0] m_paddr;
   logic [15:0] m_pdata;
   bit          m_pwen;
   bit          m_err;

   task automatic model_reset();
      q.delete();
      pend.delete();
      m_iptr  = 0;
      m_hold  = 0;
      m_ptag  = '0;
      m_paddr = '0;
      m_pdata = '0;
      m_pwen  = 0;
      m_err   = 0;
   endtask

   task automatic idle_inputs();
      req_valid       = 1'b0;
      req_addr        = '0;
      req_wdata       = '0;
      req_wen         = 1'b0;
      resp_ready      = 1'b0;
      freeze_inputs   = 1'b0;
      port_req_tag_in = '0;
      port_data_in    = '0;
      port_valid_in   = 1'b0;
   endtask

   // Called at a falling edge with inputs already driven. Checks every
   // output against the model, advances one rising edge, updates the model.
   task automatic step();
      bit   e_ready, e_rv, take, acc, ret, found;
      ent_t e;
      #1;
      e_ready = (q.size() < 4) && (!m_hold || !freeze_inputs);
      e_rv    = (q.size() > 0) && q[0].done;
      chk("req_ready", req_ready, e_ready);
      chk("resp_valid", resp_valid, e_rv);
      chk("port_valid", port_valid, m_hold);
      chk("tag_err", tag_err, m_err);
      if (m_hold) begin
         chk("port_req_tag", port_req_tag, m_ptag);
         chk("port_addr", port_addr, m_paddr);
         chk("port_data", port_data, m_pdata);
         chk("port_wen", port_wen, m_pwen);
      end
      if (e_rv) begin
         chk("resp_rdata", resp_rdata, q[0].data);
         chk("resp_wen", resp_wen, q[0].wen);
      end
      take = m_hold && !freeze_inputs;
      acc  = req_valid && e_ready;
      ret  = e_rv && resp_ready;
      @(posedge clk);
      if (port_valid_in) begin
         found = 0;
         foreach (q[i]) begin
            if (!found && q[i].tag == port_req_tag_in && !q[i].done) begin
               q[i].done = 1;
               q[i].data = q[i].wen ? 16'h0 : port_data_in;
               found = 1;
            end
         end
         if (!found) m_err = 1;
         for (int i = 0; i < pend.size(); i++) begin
            if (pend[i] == port_req_tag_in) begin
               pend.delete(i);
               break;
            end
         end
      end
      if (ret) q.delete(0);
      if (take) pend.push_back(m_ptag);
      if (acc) begin
         e.tag  = 2'(m_iptr);
         e.wen  = req_wen;
         e.done = 0;
         e.data = '0;
         q.push_back(e);
         m_hold  = 1;
         m_ptag  = 2'(m_iptr);
         m_paddr = req_addr;
         m_pdata = req_wdata;
         m_pwen  = req_wen;
         m_iptr  = (m_iptr + 1) % 4;
      end else if (take) begin
         m_hold = 0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      #1;
      model_reset();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_resp_wen", resp_wen, 0);
      chk("rst_port_tag", port_req_tag, 0);
      chk("rst_port_addr", port_addr, 0);
      chk("rst_port_data", port_data, 0);
      chk("rst_port_wen", port_wen, 0);
      chk("rst_port_valid", port_valid, 0);
      chk("rst_tag_err", tag_err, 0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic respond(input logic [1:0] t, input logic [15:0] d);
      port_valid_in   = 1'b1;
      port_req_tag_in = t;
      port_data_in    = d;
   endtask

   task automatic drive_req(input logic [11:0] a, input logic [15:0] d, input logic w);
      req_valid = 1'b1;
      req_addr  = a;
      req_wdata = d;
      req_wen   = w;
   endtask

   // Returns responses for everything outstanding and retires it.
   task automatic drain();
      int n = 0;
      req_valid     = 1'b0;
      freeze_inputs = 1'b0;
      while ((q.size() > 0 || m_hold) && n < 100) begin
         resp_ready    = 1'b1;
         port_valid_in = 1'b0;
         if (pend.size() > 0 && ($urandom % 2) == 1) begin
            int k = $urandom_range(0, pend.size() - 1);
            respond(pend[k], 16'($urandom));
         end
         step();
         n++;
      end
      port_valid_in = 1'b0;
      resp_ready    = 1'b0;
      chk("drain_port_valid", port_valid, 0);
      chk("drain_resp_valid", resp_valid, 0);
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      do_reset();

      // single read
      drive_req(12'h123, 16'h0, 1'b0);
      step();
      req_valid = 1'b0;
      chk("rd_port_valid", port_valid, 1);
      chk("rd_port_tag", port_req_tag, 0);
      chk("rd_port_addr", port_addr, 12'h123);
      step();
      respond(2'd0, 16'hBEEF);
      step();
      port_valid_in = 1'b0;
      chk("rd_resp_valid", resp_valid, 1);
      chk("rd_resp_rdata", resp_rdata, 16'hBEEF);
      chk("rd_resp_wen", resp_wen, 0);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;

      // freeze: request held stable, released cycle also accepts the next one
      drive_req(12'h200, 16'h0, 1'b0);
      step();
      freeze_inputs = 1'b1;
      drive_req(12'h201, 16'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("frz_port_addr", port_addr, 12'h200);
         chk("frz_port_valid", port_valid, 1);
      end
      freeze_inputs = 1'b0;
      step();
      req_valid = 1'b0;
      chk("frz_next_addr", port_addr, 12'h201);
      chk("frz_next_tag", port_req_tag, 2);
      drain();

      // full and reorder
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive_req(12'h010 + 12'(i), 16'h0, 1'b0);
         step();
         chk("full_tag", port_req_tag, i);
      end
      drive_req(12'h099, 16'h0, 1'b0);
      step();
      chk("full_ready", req_ready, 0);
      req_valid = 1'b0;
      respond(2'd2, 16'h00A2); step();
      respond(2'd0, 16'h00A0); step();
      respond(2'd3, 16'h00A3); step();
      respond(2'd1, 16'h00A1); step();
      port_valid_in = 1'b0;
      chk("ro_head0", resp_rdata, 16'h00A0);
      resp_ready = 1'b1;
      drive_req(12'h0AB, 16'h0, 1'b0);
      step();
      chk("ro_ready_after_ret", req_ready, 1);
      chk("ro_head1", resp_rdata, 16'h00A1);
      step();
      req_valid = 1'b0;
      chk("ro_5th_tag", port_req_tag, 0);
      chk("ro_5th_addr", port_addr, 12'h0AB);
      chk("ro_head2", resp_rdata, 16'h00A2);
      step();
      chk("ro_head3", resp_rdata, 16'h00A3);
      step();
      drain();

      // write
      drive_req(12'h7FF, 16'h5555, 1'b1);
      step();
      req_valid = 1'b0;
      chk("wr_port_wen", port_wen, 1);
      chk("wr_port_data", port_data, 16'h5555);
      chk("wr_port_addr", port_addr, 12'h7FF);
      step();
      respond(m_ptag, 16'h1234);
      step();
      port_valid_in = 1'b0;
      chk("wr_resp_valid", resp_valid, 1);
      chk("wr_resp_wen", resp_wen, 1);
      chk("wr_resp_rdata", resp_rdata, 0);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;

      // randomized traffic
      for (int c = 0; c < 2000; c++) begin
         req_valid     = 1'($urandom);
         req_addr      = 12'($urandom);
         req_wdata     = 16'($urandom);
         req_wen       = 1'($urandom);
         freeze_inputs = (($urandom % 4) == 0);
         resp_ready    = (($urandom % 3) != 0);
         port_valid_in = 1'b0;
         if (pend.size() > 0 && ($urandom % 2) == 1) begin
            int k = $urandom_range(0, pend.size() - 1);
            respond(pend[k], 16'($urandom));
         end
         step();
      end
      drain();

      // tag error
      do_reset();
      drive_req(12'h321, 16'h0, 1'b0);
      step();
      req_valid = 1'b0;
      step();
      respond(2'd2, 16'hDEAD);
      step();
      port_valid_in = 1'b0;
      chk("te_set", tag_err, 1);
      step();
      chk("te_sticky", tag_err, 1);
      respond(2'd0, 16'h0F0F);
      step();
      port_valid_in = 1'b0;
      chk("te_resp_valid", resp_valid, 1);
      chk("te_resp_rdata", resp_rdata, 16'h0F0F);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      chk("te_still_set", tag_err, 1);
      chk("te_retired", resp_valid, 0);

      // reset in the middle of traffic
      drive_req(12'h0A0, 16'h0, 1'b0);
      step();
      freeze_inputs = 1'b1;
      drive_req(12'h0A1, 16'h0, 1'b1);
      step();
      do_reset();
      drive_req(12'h0AA, 16'h0, 1'b0);
      step();
      req_valid = 1'b0;
      chk("mid_rst_tag", port_req_tag, 0);
      chk("mid_rst_addr", port_addr, 12'h0AA);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/port_requester.md
# port_requester

Client-side initiator for one port of the three-port banked memory cluster. It takes read and write requests from a client over a valid/ready handshake and assigns each one a 2-bit request tag. It drives the request onto the cluster port and holds it while the cluster asserts `freeze_inputs`. Responses can return out of order across banks; a tag-indexed reorder buffer matches them and delivers them to the client in issue order.

## Interface
- `ADDR_W`, 12, address width of the cluster port.
- `DATA_W`, 16, data width of the cluster port.
- `TAG_W`, 2, tag width; the number of outstanding requests is fixed at 2**TAG_W = 4.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  client request present.
- `req_ready`  out  1  request accepted at this edge when high together with `req_valid`.
- `req_addr`  in  ADDR_W  client request address.
- `req_wdata`  in  DATA_W  client write data.
- `req_wen`  in  1  1 = write, 0 = read.
- `resp_valid`  out  1  head-of-order response available.
- `resp_ready`  in  1  client consumes the response.
- `resp_rdata`  out  DATA_W  read data; 0 for writes.
- `resp_wen`  out  1  the response belongs to a write.
- `port_req_tag`  out  TAG_W  tag driven to the cluster.
- `port_addr`  out  ADDR_W  address driven to the cluster.
- `port_data`  out  DATA_W  write data driven to the cluster.
- `port_wen`  out  1  write enable driven to the cluster.
- `port_valid`  out  1  request valid driven to the cluster.
- `freeze_inputs`  in  1  cluster is masking its inputs this cycle; the request is not taken.
- `port_req_tag_in`  in  TAG_W  response tag from the cluster.
- `port_data_in`  in  DATA_W  response data from the cluster.
- `port_valid_in`  in  1  response valid from the cluster.
- `tag_err`  out  1  sticky flag: a response arrived for an unallocated or already-completed tag.

## Operation
- **State:**
  - issue pointer `iptr` (TAG_W bits, wraps 3→0);
  - retire pointer `rptr` (TAG_W bits, wraps 3→0);
  - `count` (0..4, 3 bits);
  - hold register: `port_*` outputs plus `hold_valid`, which drives `port_valid`;
  - 4-entry reorder buffer (ROB), each entry holding `alloc`, `done`, `wen` and `data`.
- **Port take:** `take = port_valid & ~freeze_inputs`. The cluster captures the request at the edge where `take` is high.
- **Request acceptance:**
  - `req_ready = (count < 4) & (~hold_valid | take)`. This is combinational on `freeze_inputs` by design.
  - On accept, the hold register loads `{iptr, req_addr, req_wdata, req_wen}` and `port_valid` stays or goes to 1.
  - At the same time, ROB[`iptr`] sets `alloc`=1, `done`=0, `wen`=`req_wen`, and `iptr` increments.
  - If `take` is high with no accept, `port_valid` goes to 0.
  - While `freeze_inputs` is high, all `port_*` outputs hold stable.
- **Response capture:** every request, read or write, returns exactly one response. On `port_valid_in`, with t = `port_req_tag_in`:
  - if ROB[t] has `alloc`=1 and `done`=0: set `done`=1 and store `data` = `port_data_in` (forced to 0 when the entry's `wen`=1);
  - otherwise: set `tag_err`=1 and leave the ROB unchanged.
- **Retire:**
  - `resp_valid = ROB[rptr].done`; `resp_rdata` and `resp_wen` come from ROB[`rptr`].
  - On `resp_valid & resp_ready`: clear `alloc` and `done` of ROB[`rptr`] and increment `rptr`.
- **Count:** +1 on accept, −1 on retire. Both in one cycle leaves it unchanged, including when full or empty.
- **Full:** at count=4, `req_ready`=0 until a retire edge. A retire at count=4 does not enable an accept in the same cycle.
- **Same-tag events in one cycle:** a response to the head entry and its retire cannot coincide, because `done` must be set first. A response to tag t can coincide with a new allocation of t only on a protocol violation; the allocation wins and `tag_err` is set.

## Timing
- **Reset values:** all outputs 0, `iptr`=`rptr`=0, `count`=0, all ROB bits 0, `tag_err`=0.
- **Reset mid-operation:** all in-flight state is discarded. The cluster is reset on the same `reset` domain, so no stale responses are expected.
- **Issue latency:** a client request accepted at edge N drives `port_valid` from N+1 onward. Each frozen cycle adds one cycle.
- **Return latency:** a response captured at edge K makes `resp_valid` visible after K, if it is the head entry. There is no combinational path from `port_*_in` to `resp_*`.
- **Throughput:** one accept per cycle when unfrozen and count < 4.

## Structure
- Shared package `port_req_pkg` holds `ADDR_W`, `DATA_W`, `TAG_W`, `NUM_TAGS`=4, and the ROB entry type `{alloc, done, wen, data}`.
- One sub-module, `tag_reorder_buffer`, contains:
  - the ROB entries, `rptr` and the `tag_err` logic;
  - ports for allocate (tag, wen), complete (tag, data), and head (valid, data, wen, pop).
- The top level keeps the hold register, `iptr`, `count` and the handshake logic.

## Test plan
- **Reset:** assert `reset` mid-transfer → all outputs 0; the next accepted request carries tag 0.
- **Single read:** read addr 0x123, no freeze → `port_valid` with tag 0 one cycle later. A response with tag 0 and data 0xBEEF → `resp_valid`, `resp_rdata`=0xBEEF, `resp_wen`=0.
- **Freeze:** hold `freeze_inputs`=1 for 3 cycles with a request pending → `port_*` outputs stable and `req_ready`=0. Release → request taken, and the next request is accepted in the same cycle.
- **Full and reorder:** issue 4 reads (tags 0..3) → `req_ready`=0. Return responses in tag order 2,0,3,1 with data 0xA2,0xA0,0xA3,0xA1 → the client sees 0xA0,0xA1,0xA2,0xA3. Then accept a 5th request with tag 0.
- **Write:** write addr 0x7FF, data 0x5555 → response with `resp_wen`=1 and `resp_rdata`=0.
- **Tag error:** response with tag 2 when only tag 0 is outstanding → `tag_err`=1 and stays 1; tag 0 still completes normally.
